// File: rtl/gray_rx_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_rx_decoder_if
//  Description : Signal bundle between a Gray-count receiver and its user.
//                master : drives gray_in / clr_err, observes the decode.
//                slave  : the decoder itself.
//  Ports       : gray_in[W]  Gray-coded count from a foreign clock domain
//                clr_err     synchronous clear of err / err_cnt
//                bin_out[W]  registered binary decode
//                bin_valid   bin_out holds a decoded sample
//                inc / dec   one-cycle step pulses
//                err         sticky illegal-transition flag
//                err_cnt[8]  saturating illegal-transition count
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_rx_decoder_if #(
   parameter int W = 4
);
   logic [W-1:0] gray_in;
   logic         clr_err;
   logic [W-1:0] bin_out;
   logic         bin_valid;
   logic         inc;
   logic         dec;
   logic         err;
   logic [7:0]   err_cnt;

   modport master (
      output gray_in, clr_err,
      input  bin_out, bin_valid, inc, dec, err, err_cnt
   );

   modport slave (
      input  gray_in, clr_err,
      output bin_out, bin_valid, inc, dec, err, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/gray_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : gray_rx_decoder
//  Description : Synchronizes a Gray-coded counter from another clock domain,
//                decodes it to binary and classifies each step as +1, -1,
//                no change, or illegal (sticky err + saturating err_cnt).
//  Ports       : clk   clock, rising edge
//                rst   asynchronous active-high reset
//                bus   gray_rx_decoder_if.slave (gray_in, clr_err in;
//                      bin_out, bin_valid, inc, dec, err, err_cnt out)
//  Parameters  : W            Gray/binary width (2..16)
//                SYNC_STAGES  synchronizer depth (2..4)
//  Revision    : 1.0  initial release
// ============================================================================
module gray_rx_decoder #(
   parameter int W           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic         clk,
   input  wire logic         rst,
   gray_rx_decoder_if.slave  bus
);

   localparam int                  c_FILL_W    = $clog2(SYNC_STAGES + 1);
   localparam logic [c_FILL_W-1:0] c_FILL_DONE = c_FILL_W'(SYNC_STAGES);
   localparam logic [W-1:0]        c_STEP_UP   = W'(1);
   localparam logic [W-1:0]        c_STEP_DN   = {W{1'b1}};
   localparam logic [7:0]          c_CNT_MAX   = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Synchronizer chain; only the last stage is ever decoded.
   // ------------------------------------------------------------------
   logic [W-1:0] r_sync [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= bus.gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   logic [W-1:0] w_gs;
   assign w_gs = r_sync[SYNC_STAGES-1];

   // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
   // above its position, which equals the iterative b[i]=b[i+1]^g[i] form.
   logic [W-1:0] w_bin;

   for (genvar gi = 0; gi < W; gi++) begin : g_decode
      assign w_bin[gi] = ^(w_gs >> gi);
   end

   // ------------------------------------------------------------------
   // Step classification against the previously accepted sample.
   // Modular subtraction makes the wrap-around cases fall out naturally.
   // ------------------------------------------------------------------
   state_t        r_state;
   logic [c_FILL_W-1:0] r_fill;
   logic [W-1:0]  r_bin_out;
   logic          r_bin_valid;
   logic          r_inc;
   logic          r_dec;
   logic          r_err;
   logic [7:0]    r_err_cnt;

   logic [W-1:0]  w_diff;
   logic          w_is_inc;
   logic          w_is_dec;
   logic          w_illegal;
   logic [7:0]    w_cnt_next;

   assign w_diff     = w_bin - r_bin_out;
   assign w_is_inc   = (w_diff == c_STEP_UP);
   assign w_is_dec   = (w_diff == c_STEP_DN);
   assign w_illegal  = (w_diff != '0) && !w_is_inc && !w_is_dec;
   assign w_cnt_next = (r_err_cnt == c_CNT_MAX) ? c_CNT_MAX : r_err_cnt + 8'd1;

   // ------------------------------------------------------------------
   // Control FSM with registered outputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_fill      <= '0;
         r_bin_out   <= '0;
         r_bin_valid <= 1'b0;
         r_inc       <= 1'b0;
         r_dec       <= 1'b0;
         r_err       <= 1'b0;
         r_err_cnt   <= '0;
      end else begin
         r_inc <= 1'b0;
         r_dec <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Wait until the chain holds post-reset samples only, then
               // take the first value as the reference without judging it.
               if (r_fill != c_FILL_DONE) begin
                  r_fill <= r_fill + c_FILL_W'(1);
               end else begin
                  r_bin_out   <= w_bin;
                  r_bin_valid <= 1'b1;
                  r_state     <= ST_TRACK;
               end
            end

            ST_TRACK, ST_ERR: begin
               // Always resync, so an illegal jump becomes the new reference.
               r_bin_out <= w_bin;
               r_inc     <= w_is_inc;
               r_dec     <= w_is_dec;
               if (w_illegal) begin
                  // A coincident clear still leaves this cycle's error counted.
                  r_err     <= 1'b1;
                  r_err_cnt <= bus.clr_err ? 8'd1 : w_cnt_next;
                  r_state   <= ST_ERR;
               end else if (bus.clr_err) begin
                  r_err     <= 1'b0;
                  r_err_cnt <= '0;
                  r_state   <= ST_TRACK;
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.bin_out   = r_bin_out;
   assign bus.bin_valid = r_bin_valid;
   assign bus.inc       = r_inc;
   assign bus.dec       = r_dec;
   assign bus.err       = r_err;
   assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gray_rx_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_rx_decoder
//  Description : Self-checking bench for gray_rx_decoder (W=4, SYNC_STAGES=2).
//                Directed vector table, hand-written reset / saturation
//                sequences, and randomized steps against a lookup-table model.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_rx_decoder;

   logic clk;
   logic rst;

   gray_rx_decoder_if #(.W(4)) bus ();

   gray_rx_decoder #(
      .W           (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [3:0] last_bin;

   // Reference tables: binary<->Gray by the textbook n ^ (n >> 1) mapping.
   logic [3:0] b2g [16];
   logic [3:0] g2b [16];

   typedef struct {
      logic [3:0] gray;
      logic       clr;
      logic [3:0] bin;
      logic       inc;
      logic       dec;
      logic       err;
      logic [7:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string tag, input string fld,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s actual=%0d required=%0d", tag, fld, act, exp);
      end
   endtask

   // One Gray change, optional clr_err aligned with the edge that evaluates it.
   task automatic step(input string tag, input logic [3:0] g, input logic c,
                       input logic [3:0] eb, input logic ei, input logic ed,
                       input logic ee, input logic [7:0] ec);
      @(negedge clk);
      bus.gray_in = g;
      @(posedge clk);
      @(posedge clk);
      #1;
      check(tag, "latency_hold", bus.bin_out, last_bin);
      @(negedge clk);
      bus.clr_err = c;
      @(posedge clk);
      #1;
      check(tag, "bin_out", bus.bin_out, eb);
      check(tag, "bin_valid", bus.bin_valid, 1'b1);
      check(tag, "inc", bus.inc, ei);
      check(tag, "dec", bus.dec, ed);
      check(tag, "err", bus.err, ee);
      check(tag, "err_cnt", bus.err_cnt, ec);
      @(negedge clk);
      bus.clr_err = 1'b0;
      @(posedge clk);
      #1;
      check(tag, "pulse_width", {bus.inc, bus.dec}, 2'b00);
      last_bin = eb;
   endtask

   task automatic do_reset(input string tag, input logic [3:0] g, input logic [3:0] eb);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check(tag, "rst_bin_out", bus.bin_out, 4'd0);
      check(tag, "rst_flags", {bus.bin_valid, bus.inc, bus.dec, bus.err}, 4'b0000);
      check(tag, "rst_err_cnt", bus.err_cnt, 8'd0);
      bus.gray_in = g;
      bus.clr_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check(tag, "fill1_valid", bus.bin_valid, 1'b0);
      @(posedge clk);
      #1;
      check(tag, "fill2_valid", bus.bin_valid, 1'b0);
      @(posedge clk);
      #1;
      check(tag, "load_valid", bus.bin_valid, 1'b1);
      check(tag, "load_bin", bus.bin_out, eb);
      check(tag, "load_flags", {bus.inc, bus.dec, bus.err}, 3'b000);
      check(tag, "load_err_cnt", bus.err_cnt, 8'd0);
      last_bin = eb;
   endtask

   // Toggle gray_in every cycle for n cycles between two values.
   task automatic toggle(input int n, input logic [3:0] ga, input logic [3:0] gb);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.gray_in = (i % 2 == 0) ? ga : gb;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] m_prev;
      logic       m_err;
      logic [7:0] m_cnt;

      rst         = 1'b1;
      bus.gray_in = 4'b0000;
      bus.clr_err = 1'b0;
      last_bin    = 4'd0;

      for (int n = 0; n < 16; n++) begin
         b2g[n]              = 4'(n ^ (n >> 1));
         g2b[4'(n ^ (n >> 1))] = 4'(n);
      end

      //              gray     clr   bin   inc dec err cnt
      tbl.push_back('{4'b0001, 1'b0, 4'd1, 1, 0, 0, 8'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'd2, 1, 0, 0, 8'd0});
      tbl.push_back('{4'b0010, 1'b0, 4'd3, 1, 0, 0, 8'd0});
      tbl.push_back('{4'b0011, 1'b0, 4'd2, 0, 1, 0, 8'd0});
      tbl.push_back('{4'b0001, 1'b0, 4'd1, 0, 1, 0, 8'd0});
      tbl.push_back('{4'b0000, 1'b0, 4'd0, 0, 1, 0, 8'd0});
      tbl.push_back('{4'b1000, 1'b0, 4'd15, 0, 1, 0, 8'd0});
      tbl.push_back('{4'b0000, 1'b0, 4'd0, 1, 0, 0, 8'd0});
      tbl.push_back('{4'b1000, 1'b0, 4'd15, 0, 1, 0, 8'd0});
      tbl.push_back('{4'b0000, 1'b0, 4'd0, 1, 0, 0, 8'd0});
      tbl.push_back('{4'b0110, 1'b0, 4'd4, 0, 0, 1, 8'd1});
      tbl.push_back('{4'b0111, 1'b0, 4'd5, 1, 0, 1, 8'd1});
      tbl.push_back('{4'b0111, 1'b1, 4'd5, 0, 0, 0, 8'd0});
      tbl.push_back('{4'b0100, 1'b0, 4'd7, 0, 0, 1, 8'd1});
      tbl.push_back('{4'b1100, 1'b0, 4'd8, 1, 0, 1, 8'd1});
      tbl.push_back('{4'b0000, 1'b0, 4'd0, 0, 0, 1, 8'd2});
      tbl.push_back('{4'b0000, 1'b1, 4'd0, 0, 0, 0, 8'd0});
      tbl.push_back('{4'b0110, 1'b1, 4'd4, 0, 0, 1, 8'd1});
      tbl.push_back('{4'b0110, 1'b1, 4'd4, 0, 0, 0, 8'd0});
      tbl.push_back('{4'b0000, 1'b1, 4'd0, 0, 0, 1, 8'd1});
      tbl.push_back('{4'b0000, 1'b1, 4'd0, 0, 0, 0, 8'd0});

      // Power-up fill with a quiet zero input.
      do_reset("boot", 4'b0000, 4'd0);

      foreach (tbl[k]) begin
         step($sformatf("vec%0d", k), tbl[k].gray, tbl[k].clr, tbl[k].bin,
              tbl[k].inc, tbl[k].dec, tbl[k].err, tbl[k].cnt);
      end

      // Saturation: 254 illegal jumps first, then 46 more past the ceiling.
      toggle(254, 4'b0110, 4'b0000);
      check("sat", "cnt_254", bus.err_cnt, 8'd254);
      check("sat", "err_254", bus.err, 1'b1);
      toggle(46, 4'b0110, 4'b0000);
      check("sat", "cnt_255", bus.err_cnt, 8'd255);
      check("sat", "bin_after", bus.bin_out, 4'd0);
      last_bin = 4'd0;
      step("clr_vs_err", 4'b0110, 1'b1, 4'd4, 0, 0, 1, 8'd1);

      // Build err_cnt=7, then reset out of ERR.
      toggle(6, 4'b0000, 4'b0110);
      check("pre_rst", "err_cnt", bus.err_cnt, 8'd7);
      do_reset("rst_in_err", 4'b0110, 4'd4);

      // Randomized steps against the rule-level model.
      m_prev = 4'd4;
      m_err  = 1'b0;
      m_cnt  = 8'd0;
      for (int s = 0; s < 150; s++) begin
         logic [3:0] n;
         logic [3:0] d;
         logic       c;
         logic       ill;
         int         kind;
         kind = $urandom_range(0, 9);
         if (kind < 3)       n = m_prev + 4'd1;
         else if (kind < 6)  n = m_prev - 4'd1;
         else if (kind == 6) n = m_prev;
         else                n = 4'($urandom_range(0, 15));
         c   = ($urandom_range(0, 3) == 0);
         d   = n - m_prev;
         ill = (d != 4'd0) && (d != 4'd1) && (d != 4'd15);
         if (ill) begin
            m_err = 1'b1;
            m_cnt = c ? 8'd1 : ((m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1);
         end else if (c) begin
            m_err = 1'b0;
            m_cnt = 8'd0;
         end
         step($sformatf("rnd%0d", s), b2g[n], c, g2b[b2g[n]],
              (d == 4'd1), (d == 4'd15), m_err, m_cnt);
         m_prev = n;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gray_rx_decoder.md
GRAY_RX_DECODER -- requirements
Module: gray_rx_decoder

Interface
REQ-001 Parameter W, default 4: Gray/binary width (2..16).
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on gray_in (2..4).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 gray_in  input  W  Gray-coded count from a foreign clock domain.
REQ-006 clr_err  input  1  synchronous clear of err and err_cnt.
REQ-007 bin_out  output  W  registered binary decode of the synchronized Gray value.
REQ-008 bin_valid  output  1  high while bin_out holds a decoded sample (TRACK or ERR state).
REQ-009 inc  output  1  one-cycle pulse: new value = previous + 1 mod 2^W.
REQ-010 dec  output  1  one-cycle pulse: new value = previous - 1 mod 2^W.
REQ-011 err  output  1  sticky flag for an illegal transition.
REQ-012 err_cnt  output  8  saturating count of illegal transitions.

Function
REQ-013 gray_in SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is g_s.
REQ-014 Decode SHALL be b[W-1]=g_s[W-1], b[i]=b[i+1] XOR g_s[i] for i=W-2..0.
REQ-015 Latency SHALL be SYNC_STAGES+1 edges from a gray_in change to bin_out update.
REQ-016 FSM states SHALL be IDLE, TRACK, ERR; reset state IDLE.
REQ-017 IDLE: a fill counter SHALL count SYNC_STAGES edges after reset release.
REQ-018 On the next edge after the fill count completes, the FSM SHALL load bin_out=b, set bin_valid=1, and enter TRACK, with no inc/dec/err.
REQ-019 In TRACK/ERR, each edge SHALL compute d=(b - bin_out) mod 2^W, then load bin_out=b.
REQ-020 d=0: no pulse.
REQ-021 d=1: inc=1 for exactly one cycle.
REQ-022 d=2^W-1: dec=1 for exactly one cycle.
REQ-023 Wrap-around (2^W-1 -> 0 or 0 -> 2^W-1) SHALL be a legal inc or dec respectively.
REQ-024 Any other d is illegal: no inc/dec, err<=1, err_cnt<=err_cnt+1 saturating at 255, and the FSM enters/stays in ERR.
REQ-025 bin_out SHALL resync to the new value on an illegal transition; the next comparison uses it.
REQ-026 ERR with clr_err=1 and no illegal transition that cycle: err<=0, err_cnt<=0, enter TRACK.
REQ-027 TRACK with clr_err=1: err_cnt<=0.
REQ-028 Illegal transition in the same cycle as clr_err: error wins; err=1, err_cnt=1, FSM=ERR.
REQ-029 clr_err in IDLE: no effect.
REQ-030 inc, dec and err_cnt increments SHALL be mutually exclusive within a cycle.

Reset
REQ-031 rst=1 SHALL immediately force bin_out=0, bin_valid=0, inc=0, dec=0, err=0, err_cnt=0, sync chain=0, fill counter=0, FSM=IDLE.
REQ-032 rst asserted mid-TRACK/ERR SHALL discard all history; after release the block repeats the IDLE fill sequence.

Verification (W=4, SYNC_STAGES=2)
REQ-033 Release rst with gray_in=0000 held -> bin_valid rises on the 3rd edge after release, bin_out=0, inc/dec/err stay 0.
REQ-034 gray_in 0000->0001->0011->0010, 4 cycles apart -> bin_out 0,1,2,3, each 3 edges after the change, with one inc pulse each.
REQ-035 gray_in 1000->0000 -> bin_out 15->0 with inc pulse; then 0000->1000 -> bin_out 0->15 with dec pulse; err=0 throughout.
REQ-036 From 0000 jump to 0110 -> bin_out=4, err=1, err_cnt=1, no inc/dec; later 0110->0111 (5) gives inc and err stays 1; clr_err pulse -> err=0, err_cnt=0, TRACK.
REQ-037 300 alternating illegal jumps (0000<->0110) -> err_cnt saturates at 255 with no wrap; a simultaneous clr_err and illegal jump -> err=1, err_cnt=1.
REQ-038 rst pulse while in ERR with err_cnt=7 -> all outputs 0 during rst; after release the 3-edge fill then bin_valid=1 with err=0.
